fwrisc_exec_mem_stim: RTL and testbench

Parametrised load/store stimulus and data-memory model for fwrisc exec-stage benches, formal and simulation. It accepts one memory instruction at a time on a config handshake, drives it to the exec stage as a decoded LDST op, and answers the exec data bus from a small byte-addressable backing memory. The memory responder has a configurable wait-state count, so loads return previously stored data. It sits in place of the decoder and data memory around `fwrisc_exec`.

---
 rtl/fwrisc_exec_mem_stim.sv | 248 ++++++++++++++++++++++++
 tb/tb_fwrisc_exec_mem_stim.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_exec_mem_stim.sv
// Load/store stimulus and wait-state data-memory model standing in for the
// decoder and data memory around fwrisc_exec.
module fwrisc_exec_mem_stim #(
  parameter int unsigned MEM_DEPTH_LOG2 = 6,
  parameter int unsigned WAIT_STATES    = 0,
  parameter int unsigned ALIGN          = 1,
  parameter logic [31:0] MTVEC          = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_op,
  input  logic [31:0] cfg_base,
  input  logic [7:0]  cfg_off,
  input  logic [31:0] cfg_data,
  input  logic [4:0]  cfg_rd,
  output logic        decode_valid,
  input  logic        instr_complete,
  output logic        instr_c,
  output logic [4:0]  op_type,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] op_c,
  output logic [5:0]  op,
  output logic [5:0]  rd,
  output logic [31:0] mtvec,
  input  logic        dvalid,
  input  logic [31:0] daddr,
  input  logic        dwrite,
  input  logic [3:0]  dwstb,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        dready,
  output logic [15:0] instr_count
);

  localparam logic [3:0] OP_LB      = 4'd0;
  localparam logic [3:0] OP_LH      = 4'd1;
  localparam logic [3:0] OP_LW      = 4'd2;
  localparam logic [3:0] OP_LBU     = 4'd3;
  localparam logic [3:0] OP_LHU     = 4'd4;
  localparam logic [3:0] OP_SB      = 4'd5;
  localparam logic [3:0] OP_SH      = 4'd6;
  localparam logic [3:0] OP_SW      = 4'd7;
  localparam logic [3:0] OP_NUM_MEM = 4'd8;

  localparam logic [4:0] OP_TYPE_LDST = 5'd2;
  localparam int unsigned MEM_WORDS = 2 ** MEM_DEPTH_LOG2;

  typedef enum logic {
    IDLE,
    BUSY
  } issue_state_e;

  typedef enum logic [1:0] {
    MIDLE,
    MWAIT,
    MRESP
  } mem_state_e;

  // ---------------------------------------------------------------- issue
  issue_state_e state_q, state_d;
  logic         issue_q, issue_d;
  logic [15:0]  count_q, count_d;
  logic [31:0]  op_a_q, op_a_d;
  logic [31:0]  op_b_q, op_b_d;
  logic [31:0]  op_c_q, op_c_d;
  logic [5:0]   op_q, op_d;
  logic [5:0]   rd_q, rd_d;

  logic [3:0]   op_mod;
  logic [31:0]  off_sext;
  logic [31:0]  shaped_a;
  logic [31:0]  shaped_c;

  assign op_mod   = cfg_op % OP_NUM_MEM;
  assign off_sext = {{24{cfg_off[7]}}, cfg_off};

  // Alignment drops low base bits and scales the offset by the access size.
  always_comb begin
    shaped_a = cfg_base;
    shaped_c = off_sext;
    if (ALIGN != 0) begin
      case (op_mod)
        OP_LH, OP_LHU, OP_SH: begin
          shaped_a = {cfg_base[31:1], 1'b0};
          shaped_c = {off_sext[30:0], 1'b0};
        end
        OP_LW, OP_SW: begin
          shaped_a = {cfg_base[31:2], 2'b00};
          shaped_c = {off_sext[29:0], 2'b00};
        end
        OP_LB, OP_LBU, OP_SB: begin
          shaped_a = cfg_base;
          shaped_c = off_sext;
        end
        default: begin
          shaped_a = cfg_base;
          shaped_c = off_sext;
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    count_d   = count_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_c_d    = op_c_q;
    op_d      = op_q;
    rd_d      = rd_q;
    cfg_ready = (state_q == IDLE) || !reset;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          state_d = BUSY;
          issue_d = 1'b1;
          op_a_d  = shaped_a;
          op_b_d  = cfg_data;
          op_c_d  = shaped_c;
          op_d    = {2'b00, op_mod};
          rd_d    = {1'b0, cfg_rd};
        end
      end
      BUSY: begin
        if (instr_complete) begin
          state_d = IDLE;
          issue_d = 1'b0;
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      issue_q <= 1'b0;
      count_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_c_q  <= '0;
      op_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      count_q <= count_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      op_c_q  <= op_c_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  assign decode_valid = reset && issue_q && !instr_complete;
  assign instr_c      = 1'b0;
  assign op_type      = OP_TYPE_LDST;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_c         = op_c_q;
  assign op           = op_q;
  assign rd           = rd_q;
  assign mtvec        = MTVEC;
  assign instr_count  = count_q;

  // --------------------------------------------------------------- memory
  mem_state_e                mstate_q, mstate_d;
  logic [31:0]               wcnt_q, wcnt_d;
  logic [MEM_DEPTH_LOG2-1:0] midx_q, midx_d;
  logic                      mwrite_q, mwrite_d;
  logic [3:0]                mwstb_q, mwstb_d;
  logic [31:0]               mwdata_q, mwdata_d;
  logic [31:0]               mem_q [MEM_WORDS];

  logic unused_daddr;
  assign unused_daddr = ^{daddr[31:MEM_DEPTH_LOG2+2], daddr[1:0]};

  always_comb begin
    mstate_d = mstate_q;
    wcnt_d   = wcnt_q;
    midx_d   = midx_q;
    mwrite_d = mwrite_q;
    mwstb_d  = mwstb_q;
    mwdata_d = mwdata_q;
    dready   = 1'b0;
    drdata   = '0;
    case (mstate_q)
      MIDLE: begin
        if (dvalid) begin
          midx_d   = daddr[MEM_DEPTH_LOG2+1:2];
          mwrite_d = dwrite;
          mwstb_d  = dwstb;
          mwdata_d = dwdata;
          wcnt_d   = 32'(WAIT_STATES);
          mstate_d = (WAIT_STATES > 0) ? MWAIT : MRESP;
        end
      end
      MWAIT: begin
        wcnt_d = wcnt_q - 32'd1;
        if (wcnt_q <= 32'd1) begin
          mstate_d = MRESP;
        end
      end
      MRESP: begin
        dready   = reset;
        drdata   = reset ? mem_q[midx_q] : '0;
        mstate_d = MIDLE;
      end
      default: mstate_d = MIDLE;
    endcase
  end

  // Store lanes commit on the response edge, so a load in MRESP sees pre-write data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mstate_q <= MIDLE;
      wcnt_q   <= '0;
      midx_q   <= '0;
      mwrite_q <= 1'b0;
      mwstb_q  <= '0;
      mwdata_q <= '0;
      for (int unsigned i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mstate_q <= mstate_d;
      wcnt_q   <= wcnt_d;
      midx_q   <= midx_d;
      mwrite_q <= mwrite_d;
      mwstb_q  <= mwstb_d;
      mwdata_q <= mwdata_d;
      if (mstate_q == MRESP && mwrite_q) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (mwstb_q[b]) begin
            mem_q[midx_q][8*b +: 8] <= mwdata_q[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fwrisc_exec_mem_stim.sv
// Scoreboard bench: stimulus pushes expected descriptors/responses, a negedge
// monitor pops and compares whenever a DUT presents decode_valid or dready.
module tb_fwrisc_exec_mem_stim;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [5:0]  op;
    logic [5:0]  rd;
  } opx_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_valid, instr_complete;
  logic [3:0]  cfg_op;
  logic [31:0] cfg_base, cfg_data;
  logic [7:0]  cfg_off;
  logic [4:0]  cfg_rd;
  logic        dvalid0, dvalid3, dwrite;
  logic [31:0] daddr, dwdata;
  logic [3:0]  dwstb;

  logic        cfg_ready0, decode_valid0, instr_c0, dready0;
  logic [4:0]  op_type0;
  logic [31:0] op_a0, op_b0, op_c0, mtvec0, drdata0;
  logic [5:0]  op0, rd0;
  logic [15:0] instr_count0;

  logic        cfg_ready3, decode_valid3, instr_c3, dready3;
  logic [4:0]  op_type3;
  logic [31:0] op_a3, op_b3, op_c3, mtvec3, drdata3;
  logic [5:0]  op3, rd3;
  logic [15:0] instr_count3;

  fwrisc_exec_mem_stim #(
    .MEM_DEPTH_LOG2(6), .WAIT_STATES(0), .ALIGN(1), .MTVEC(32'h8000_0100)
  ) dut0 (
    .clock(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready0),
    .cfg_op(cfg_op), .cfg_base(cfg_base), .cfg_off(cfg_off), .cfg_data(cfg_data),
    .cfg_rd(cfg_rd), .decode_valid(decode_valid0), .instr_complete(instr_complete),
    .instr_c(instr_c0), .op_type(op_type0), .op_a(op_a0), .op_b(op_b0), .op_c(op_c0),
    .op(op0), .rd(rd0), .mtvec(mtvec0), .dvalid(dvalid0), .daddr(daddr),
    .dwrite(dwrite), .dwstb(dwstb), .dwdata(dwdata), .drdata(drdata0),
    .dready(dready0), .instr_count(instr_count0)
  );

  fwrisc_exec_mem_stim #(
    .MEM_DEPTH_LOG2(6), .WAIT_STATES(3), .ALIGN(1), .MTVEC(32'h0)
  ) dut3 (
    .clock(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
    .cfg_op(cfg_op), .cfg_base(cfg_base), .cfg_off(cfg_off), .cfg_data(cfg_data),
    .cfg_rd(cfg_rd), .decode_valid(decode_valid3), .instr_complete(instr_complete),
    .instr_c(instr_c3), .op_type(op_type3), .op_a(op_a3), .op_b(op_b3), .op_c(op_c3),
    .op(op3), .rd(rd3), .mtvec(mtvec3), .dvalid(dvalid3), .daddr(daddr),
    .dwrite(dwrite), .dwstb(dwstb), .dwdata(dwdata), .drdata(drdata3),
    .dready(dready3), .instr_count(instr_count3)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_count = '0;
  rsp_t q0[$];
  rsp_t q3[$];
  opx_t qop[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor
  logic dv_prev = 1'b0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (decode_valid0 && !dv_prev) begin
        if (qop.size() == 0) begin
          chk("unexpected_decode_valid", 32'd1, 32'd0);
        end else begin
          opx_t e;
          e = qop.pop_front();
          chk("op_a", op_a0, e.a);
          chk("op_b", op_b0, e.b);
          chk("op_c", op_c0, e.c);
          chk("op", {26'd0, op0}, {26'd0, e.op});
          chk("rd", {26'd0, rd0}, {26'd0, e.rd});
        end
      end
      dv_prev = decode_valid0;
      if (dready0) begin
        if (q0.size() == 0) chk("unexpected_dready0", 32'd1, 32'd0);
        else begin
          rsp_t r;
          r = q0.pop_front();
          chk("dready0_cycle", cyc, r.cyc);
          chk("drdata0", drdata0, r.data);
        end
      end
      if (dready3) begin
        if (q3.size() == 0) chk("unexpected_dready3", 32'd1, 32'd0);
        else begin
          rsp_t r;
          r = q3.pop_front();
          chk("dready3_cycle", cyc, r.cyc);
          chk("drdata3", drdata3, r.data);
        end
      end
    end else begin
      dv_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] base, input logic [7:0] off,
                       input logic [31:0] data, input logic [4:0] r,
                       input logic [31:0] ea, input logic [31:0] ec, input logic [5:0] eop);
    int n = 0;
    while (!cfg_ready0 && n < 20) begin
      step();
      n++;
    end
    if (!cfg_ready0) chk("cfg_ready_timeout", 32'd0, 32'd1);
    qop.push_back('{a: ea, b: data, c: ec, op: eop, rd: {1'b0, r}});
    cfg_valid = 1'b1;
    cfg_op = o; cfg_base = base; cfg_off = off; cfg_data = data; cfg_rd = r;
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic complete();
    instr_complete = 1'b1;
    exp_count++;
    step();
    instr_complete = 1'b0;
    @(negedge clk);
    chk("instr_count", {16'd0, instr_count0}, {16'd0, exp_count});
    step();
  endtask

  task automatic mreq(input bit sel3, input logic [31:0] a, input logic wr,
                      input logic [3:0] stb, input logic [31:0] wd, input logic [31:0] exp);
    daddr = a; dwrite = wr; dwstb = stb; dwdata = wd;
    if (sel3) begin
      q3.push_back('{cyc: cyc + 4, data: exp});
      dvalid3 = 1'b1;
    end else begin
      q0.push_back('{cyc: cyc + 1, data: exp});
      dvalid0 = 1'b1;
    end
    step();
    dvalid0 = 1'b0;
    dvalid3 = 1'b0;
    repeat (sel3 ? 5 : 2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cfg_valid = 1'b1; instr_complete = 1'b0;
    cfg_op = 4'd2; cfg_base = 32'h40; cfg_off = 8'd1; cfg_data = 32'h1; cfg_rd = 5'd3;
    dvalid0 = 1'b1; dvalid3 = 1'b1; dwrite = 1'b1; daddr = 32'h0; dwstb = 4'hF; dwdata = 32'h5;

    // Reset held with traffic on both handshakes
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_decode_valid", {31'd0, decode_valid0}, 32'd0);
    chk("rst_dready0", {31'd0, dready0}, 32'd0);
    chk("rst_dready3", {31'd0, dready3}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready0}, 32'd1);
    chk("rst_instr_count", {16'd0, instr_count0}, 32'd0);
    chk("rst_op_a", op_a0, 32'd0);
    chk("rst_drdata", drdata0, 32'd0);
    chk("rst_mtvec", mtvec0, 32'h8000_0100);
    chk("rst_op_type", {27'd0, op_type0}, 32'd2);
    chk("rst_instr_c", {31'd0, instr_c0}, 32'd0);
    step();
    cfg_valid = 1'b0; dvalid0 = 1'b0; dvalid3 = 1'b0;
    reset = 1'b1;
    step();

    // SW aligned, then store through the bus
    issue(4'd7, 32'h103, 8'd2, 32'hDEADBEEF, 5'd0, 32'h100, 32'd8, 6'd7);
    mreq(1'b0, 32'h108, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0);
    complete();

    // LW, with completion and data request in the same cycle
    issue(4'd2, 32'h108, 8'd0, 32'h0, 5'd5, 32'h108, 32'h0, 6'd2);
    daddr = 32'h108; dwrite = 1'b0; dwstb = 4'h0; dwdata = 32'h0;
    q0.push_back('{cyc: cyc + 1, data: 32'hDEADBEEF});
    dvalid0 = 1'b1; instr_complete = 1'b1; exp_count++;
    step();
    dvalid0 = 1'b0; instr_complete = 1'b0;
    @(negedge clk);
    chk("instr_count_same_cycle", {16'd0, instr_count0}, {16'd0, exp_count});
    step();

    // Byte strobe merge, SB with negative offset
    mreq(1'b0, 32'h10C, 1'b1, 4'hF, 32'h11223344, 32'h0);
    issue(4'd5, 32'h10F, 8'hFF, 32'hAA, 5'd0, 32'h10F, 32'hFFFF_FFFF, 6'd5);
    mreq(1'b0, 32'h10E, 1'b1, 4'b0100, 32'h00AA0000, 32'h11223344);
    complete();
    mreq(1'b0, 32'h10C, 1'b0, 4'h0, 32'h0, 32'h11AA3344);

    // Address shaping corners
    issue(4'd1, 32'h201, 8'h80, 32'h0, 5'd31, 32'h200, 32'hFFFF_FF00, 6'd1);
    complete();
    issue(4'hF, 32'h7, 8'h7F, 32'h12345678, 5'd1, 32'h4, 32'h1FC, 6'd7);
    complete();
    issue(4'd4, 32'h203, 8'h03, 32'h0, 5'd9, 32'h202, 32'h6, 6'd4);
    complete();
    issue(4'd3, 32'h203, 8'h81, 32'h0, 5'd10, 32'h203, 32'hFFFF_FF81, 6'd3);
    complete();

    // Address wrap: 0x100 aliases word 0
    mreq(1'b0, 32'h100, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0);
    mreq(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D);
    mreq(1'b0, 32'hFFFF_F108, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF);

    // Retirement stream
    for (int i = 0; i < 100; i++) begin
      issue(4'd0, 32'h300 + 32'(i), 8'd0, 32'h0, 5'd2, 32'h300 + 32'(i), 32'h0, 6'd0);
      complete();
    end

    // Counter wrap from 0xFFFE
    force dut0.count_q = 16'hFFFE;
    @(negedge clk);
    release dut0.count_q;
    step();
    exp_count = 16'hFFFE;
    issue(4'd0, 32'h0, 8'd0, 32'h0, 5'd0, 32'h0, 32'h0, 6'd0);
    complete();
    issue(4'd0, 32'h0, 8'd0, 32'h0, 5'd0, 32'h0, 32'h0, 6'd0);
    complete();
    chk("instr_count_wrapped", {16'd0, instr_count0}, 32'd0);

    // Wait states: a second dvalid during the wait is ignored
    daddr = 32'h20; dwrite = 1'b1; dwstb = 4'hF; dwdata = 32'h55AA55AA;
    q3.push_back('{cyc: cyc + 4, data: 32'h0});
    dvalid3 = 1'b1;
    step();
    dvalid3 = 1'b0;
    step();
    daddr = 32'h24; dwdata = 32'hFFFF_FFFF; dvalid3 = 1'b1;
    step();
    dvalid3 = 1'b0;
    repeat (4) step();
    mreq(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 32'h55AA55AA);
    mreq(1'b1, 32'h24, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset during MWAIT with an instruction in flight
    issue(4'd2, 32'h20, 8'd0, 32'h0, 5'd4, 32'h20, 32'h0, 6'd2);
    daddr = 32'h20; dwrite = 1'b0; dwstb = 4'h0; dvalid3 = 1'b1;
    step();
    dvalid3 = 1'b0;
    step();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("midrst_decode_valid", {31'd0, decode_valid0}, 32'd0);
    chk("midrst_cfg_ready", {31'd0, cfg_ready0}, 32'd1);
    chk("midrst_instr_count", {16'd0, instr_count0}, 32'd0);
    step();
    mreq(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 32'h0);
    mreq(1'b0, 32'h108, 1'b0, 4'h0, 32'h0, 32'h0);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    chk("qop_drained", qop.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
